// File: rtl/exmem_pkg.sv
// Shared core definitions for the memory-op field (also used by IDEX decode):
// field positions, size encodings and the no-op constant.
package exmem_pkg;

  localparam int MEM_OP_W     = 4;
  localparam int MOP_STORE    = 3;
  localparam int MOP_UNSIGNED = 2;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } mem_size_e;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = '0;

  function automatic mem_size_e mop_size(input logic [MEM_OP_W-1:0] op);
    return mem_size_e'(op[1:0]);
  endfunction

  function automatic logic mop_is_store(input logic [MEM_OP_W-1:0] op);
    return op[MOP_STORE];
  endfunction

  function automatic logic mop_is_unsigned(input logic [MEM_OP_W-1:0] op);
    return op[MOP_UNSIGNED];
  endfunction

endpackage

// File: rtl/exmem_store_align.sv
// Combinational store lane alignment: byte strobes, replicated store data
// and the address-misalignment flag for the EX/MEM boundary.
module store_align
  import exmem_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                valid,
  input  logic                is_store,
  input  mem_size_e           size,
  input  logic [1:0]          addr_lo,
  input  logic [WordSize-1:0] rs2d,
  output logic [WordSize-1:0] store_data,
  output logic [3:0]          byte_en,
  output logic                misaligned
);

  always_comb begin
    store_data = rs2d;
    byte_en    = 4'b0000;
    misaligned = valid && (((size == SZ_HALF) && addr_lo[0]) ||
                           ((size == SZ_WORD) && (addr_lo != 2'b00)));

    case (size)
      SZ_BYTE: store_data = {(WordSize/8){rs2d[7:0]}};
      SZ_HALF: store_data = {(WordSize/16){rs2d[15:0]}};
      default: store_data = rs2d;
    endcase

    // Strobes only for real, aligned stores; loads never write memory.
    if (valid && is_store && !misaligned) begin
      case (size)
        SZ_BYTE: byte_en = 4'b0001 << addr_lo;
        SZ_HALF: byte_en = 4'b0011 << addr_lo;
        SZ_WORD: byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/exmem.sv
// EX/MEM pipeline register: captures the EX result, aligns store data,
// and emits a one-cycle fetch redirect for taken branches.
module exmem
  import exmem_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [WordSize-1:0] alu_out_in,
  input  logic [WordSize-1:0] rs2d_in,
  input  logic [4:0]          rdn_in,
  input  logic [3:0]          mem_op_in,
  input  logic                branch_taken_in,
  input  logic [WordSize-1:0] branch_addr_in,
  input  logic [WordSize-1:0] pc_in,
  output logic                valid,
  output logic [WordSize-1:0] alu_out,
  output logic [3:0]          mem_op,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] link,
  output logic [WordSize-1:0] store_data,
  output logic [3:0]          byte_en,
  output logic                redirect,
  output logic [WordSize-1:0] redirect_addr,
  output logic                misaligned
);

  logic [WordSize-1:0] store_data_p0;
  logic [3:0]          byte_en_p0;
  logic                misaligned_p0;
  logic                capture_p0;

  logic                valid_p1;
  logic [WordSize-1:0] alu_out_p1;
  logic [3:0]          mem_op_p1;
  logic [4:0]          rdn_p1;
  logic [WordSize-1:0] link_p1;
  logic [WordSize-1:0] store_data_p1;
  logic [3:0]          byte_en_p1;
  logic                redirect_p1;
  logic [WordSize-1:0] redirect_addr_p1;
  logic                misaligned_p1;

  store_align #(.WordSize(WordSize)) u_store_align (
    .valid      (valid_in),
    .is_store   (mop_is_store(mem_op_in)),
    .size       (mop_size(mem_op_in)),
    .addr_lo    (alu_out_in[1:0]),
    .rs2d       (rs2d_in),
    .store_data (store_data_p0),
    .byte_en    (byte_en_p0),
    .misaligned (misaligned_p0)
  );

  assign capture_p0 = !stall && !flush;

  // ---- p0 -> p1 stage boundary ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_p1         <= 1'b0;
      alu_out_p1       <= '0;
      mem_op_p1        <= MEM_OP_NOP;
      rdn_p1           <= '0;
      link_p1          <= '0;
      store_data_p1    <= '0;
      byte_en_p1       <= '0;
      redirect_p1      <= 1'b0;
      redirect_addr_p1 <= '0;
      misaligned_p1    <= 1'b0;
    end else begin
      // Redirect is a pulse: any non-capturing edge drops it, so a held
      // branch cannot fire twice.
      redirect_p1 <= capture_p0 && valid_in && branch_taken_in;
      if (flush) begin
        valid_p1      <= 1'b0;
        mem_op_p1     <= MEM_OP_NOP;
        rdn_p1        <= '0;
        byte_en_p1    <= '0;
        misaligned_p1 <= 1'b0;
      end else if (!stall) begin
        valid_p1         <= valid_in;
        alu_out_p1       <= alu_out_in;
        mem_op_p1        <= (valid_in && !misaligned_p0) ? mem_op_in : MEM_OP_NOP;
        rdn_p1           <= valid_in ? rdn_in : 5'd0;
        link_p1          <= pc_in + WordSize'(4);
        store_data_p1    <= store_data_p0;
        byte_en_p1       <= byte_en_p0;
        redirect_addr_p1 <= branch_addr_in;
        misaligned_p1    <= misaligned_p0;
      end
    end
  end

  assign valid         = valid_p1;
  assign alu_out       = alu_out_p1;
  assign mem_op        = mem_op_p1;
  assign rdn           = rdn_p1;
  assign link          = link_p1;
  assign store_data    = store_data_p1;
  assign byte_en       = byte_en_p1;
  assign redirect      = redirect_p1;
  assign redirect_addr = redirect_addr_p1;
  assign misaligned    = misaligned_p1;

endmodule

// File: tb/tb_exmem.sv
// Scoreboard bench for exmem: directed vectors push hand-computed expected
// outputs; a negedge monitor pops and compares them.
module tb_exmem;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_out_in = '0;
  logic [31:0] rs2d_in = '0;
  logic [4:0]  rdn_in = '0;
  logic [3:0]  mem_op_in = '0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_addr_in = '0;
  logic [31:0] pc_in = '0;

  logic        valid;
  logic [31:0] alu_out;
  logic [3:0]  mem_op;
  logic [4:0]  rdn;
  logic [31:0] link;
  logic [31:0] store_data;
  logic [3:0]  byte_en;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        misaligned;

  exmem #(.WordSize(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .stall           (stall),
    .flush           (flush),
    .valid_in        (valid_in),
    .alu_out_in      (alu_out_in),
    .rs2d_in         (rs2d_in),
    .rdn_in          (rdn_in),
    .mem_op_in       (mem_op_in),
    .branch_taken_in (branch_taken_in),
    .branch_addr_in  (branch_addr_in),
    .pc_in           (pc_in),
    .valid           (valid),
    .alu_out         (alu_out),
    .mem_op          (mem_op),
    .rdn             (rdn),
    .link            (link),
    .store_data      (store_data),
    .byte_en         (byte_en),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .misaligned      (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          id;
    logic        valid;
    logic [31:0] alu_out;
    logic [3:0]  mem_op;
    logic [4:0]  rdn;
    logic [31:0] link;
    logic [31:0] store_data;
    logic [3:0]  byte_en;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        misaligned;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic exp_t mk(input int id, input logic v, input logic [31:0] alu,
                              input logic [3:0] mop, input logic [4:0] rd,
                              input logic [31:0] lnk, input logic [31:0] sd,
                              input logic [3:0] be, input logic rdr,
                              input logic [31:0] raddr, input logic mis);
    exp_t e;
    e.id = id; e.valid = v; e.alu_out = alu; e.mem_op = mop; e.rdn = rd;
    e.link = lnk; e.store_data = sd; e.byte_en = be; e.redirect = rdr;
    e.redirect_addr = raddr; e.misaligned = mis;
    return e;
  endfunction

  function automatic exp_t zero(input int id);
    return mk(id, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
  endfunction

  task automatic chk(input int id, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got 0x%08h, expected 0x%08h", id, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk(e.id, "valid",         32'(valid),         32'(e.valid));
      chk(e.id, "alu_out",       alu_out,            e.alu_out);
      chk(e.id, "mem_op",        32'(mem_op),        32'(e.mem_op));
      chk(e.id, "rdn",           32'(rdn),           32'(e.rdn));
      chk(e.id, "link",          link,               e.link);
      chk(e.id, "store_data",    store_data,         e.store_data);
      chk(e.id, "byte_en",       32'(byte_en),       32'(e.byte_en));
      chk(e.id, "redirect",      32'(redirect),      32'(e.redirect));
      chk(e.id, "redirect_addr", redirect_addr,      e.redirect_addr);
      chk(e.id, "misaligned",    32'(misaligned),    32'(e.misaligned));
    end
  end

  task automatic step(input logic st, input logic fl, input logic v,
                      input logic [31:0] alu, input logic [31:0] rs2,
                      input logic [4:0] rd, input logic [3:0] mop, input logic bt,
                      input logic [31:0] ba, input logic [31:0] pc, input exp_t e);
    @(negedge clk);
    #1;
    stall = st; flush = fl; valid_in = v; alu_out_in = alu; rs2d_in = rs2;
    rdn_in = rd; mem_op_in = mop; branch_taken_in = bt; branch_addr_in = ba;
    pc_in = pc;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1);
  end

  initial begin
    q.push_back(zero(0));
    #12 rstn = 1'b1;

    // mem_op: SW=B, SH=A, SB=9, LW=3
    step(0, 0, 1, 32'h1000, 32'hDEADBEEF, 5'd0, 4'hB, 0, 32'h0, 32'h100,
         mk(1, 1, 32'h1000, 4'hB, 5'd0, 32'h104, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0));
    step(0, 0, 1, 32'h1003, 32'h000000A5, 5'd0, 4'h9, 0, 32'h0, 32'h104,
         mk(2, 1, 32'h1003, 4'h9, 5'd0, 32'h108, 32'hA5A5A5A5, 4'h8, 0, 32'h0, 0));
    step(0, 0, 1, 32'h1001, 32'h00001234, 5'd0, 4'hA, 0, 32'h0, 32'h108,
         mk(3, 1, 32'h1001, 4'h0, 5'd0, 32'h10C, 32'h12341234, 4'h0, 0, 32'h0, 1));
    step(0, 0, 1, 32'h1002, 32'hCAFE1234, 5'd0, 4'hA, 0, 32'h0, 32'h10C,
         mk(4, 1, 32'h1002, 4'hA, 5'd0, 32'h110, 32'h12341234, 4'hC, 0, 32'h0, 0));
    step(0, 0, 1, 32'h2004, 32'h00000055, 5'd7, 4'h3, 0, 32'h0, 32'h110,
         mk(5, 1, 32'h2004, 4'h3, 5'd7, 32'h114, 32'h00000055, 4'h0, 0, 32'h0, 0));
    step(0, 0, 1, 32'h2006, 32'h00000055, 5'd8, 4'h3, 0, 32'h0, 32'h114,
         mk(6, 1, 32'h2006, 4'h0, 5'd8, 32'h118, 32'h00000055, 4'h0, 0, 32'h0, 1));
    step(0, 0, 0, 32'h3000, 32'h00000055, 5'd9, 4'hB, 0, 32'h0, 32'h118,
         mk(7, 0, 32'h3000, 4'h0, 5'd0, 32'h11C, 32'h00000055, 4'h0, 0, 32'h0, 0));

    // Taken branch, then three stalled cycles with conflicting inputs.
    step(0, 0, 1, 32'h40, 32'h0, 5'd1, 4'h0, 1, 32'h200, 32'h180,
         mk(8, 1, 32'h40, 4'h0, 5'd1, 32'h184, 32'h0, 4'h0, 1, 32'h200, 0));
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 32'h999, 32'h77, 5'd31, 4'hB, 1, 32'h999, 32'h900,
           mk(9 + i, 1, 32'h40, 4'h0, 5'd1, 32'h184, 32'h0, 4'h0, 0, 32'h200, 0));
    step(0, 0, 1, 32'h44, 32'h0, 5'd2, 4'h0, 0, 32'h0, 32'h184,
         mk(12, 1, 32'h44, 4'h0, 5'd2, 32'h188, 32'h0, 4'h0, 0, 32'h0, 0));

    // Flush together with stall, then flush killing a pending redirect.
    step(1, 1, 1, 32'h1000, 32'hDEADBEEF, 5'd3, 4'hB, 1, 32'h300, 32'h500,
         mk(13, 0, 32'h44, 4'h0, 5'd0, 32'h188, 32'h0, 4'h0, 0, 32'h0, 0));
    step(0, 0, 1, 32'h50, 32'h0, 5'd3, 4'h0, 1, 32'h300, 32'h200,
         mk(14, 1, 32'h50, 4'h0, 5'd3, 32'h204, 32'h0, 4'h0, 1, 32'h300, 0));
    step(0, 1, 1, 32'h1000, 32'hDEADBEEF, 5'd4, 4'hB, 1, 32'h600, 32'h600,
         mk(15, 0, 32'h50, 4'h0, 5'd0, 32'h204, 32'h0, 4'h0, 0, 32'h300, 0));
    step(0, 0, 0, 32'h60, 32'h0, 5'd4, 4'h0, 1, 32'h400, 32'h300,
         mk(16, 0, 32'h60, 4'h0, 5'd0, 32'h304, 32'h0, 4'h0, 0, 32'h400, 0));

    // Reset asserted mid-cycle right after a taken-branch capture.
    step(0, 0, 1, 32'h70, 32'h0, 5'd5, 4'h0, 1, 32'h500, 32'h400, zero(17));
    #2 rstn = 1'b0;
    step(0, 0, 1, 32'h80, 32'h0, 5'd5, 4'h0, 1, 32'h500, 32'h404, zero(18));
    #2 rstn = 1'b1;
    step(0, 0, 1, 32'h0, 32'h0, 5'd6, 4'h0, 0, 32'h0, 32'hFFFFFFFC,
         mk(19, 1, 32'h0, 4'h0, 5'd6, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0));
    step(0, 0, 0, 32'h0, 32'h0, 5'd0, 4'h0, 0, 32'h0, 32'h0,
         mk(20, 0, 32'h0, 4'h0, 5'd0, 32'h4, 32'h0, 4'h0, 0, 32'h0, 0));

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/exmem.md
EXMEM -- requirements
Module: exmem

Interface
REQ-001 SHALL have parameter WordSize, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hold all stage registers.
REQ-005 SHALL have port flush  input  1  load a bubble on the next edge.
REQ-006 SHALL have port valid_in  input  1  EX-stage result is a real instruction.
REQ-007 SHALL have port alu_out_in  input  WordSize  EX result, also the memory address.
REQ-008 SHALL have port rs2d_in  input  WordSize  raw store data.
REQ-009 SHALL have port rdn_in  input  5  destination register number.
REQ-010 SHALL have port mem_op_in  input  4  memory op: bit3 store, bit2 unsigned, [1:0] size (0 none, 1 byte, 2 half, 3 word).
REQ-011 SHALL have port branch_taken_in  input  1  EX resolved branch/jump taken.
REQ-012 SHALL have port branch_addr_in  input  WordSize  branch target.
REQ-013 SHALL have port pc_in  input  WordSize  instruction PC.
REQ-014 SHALL have outputs valid (1), alu_out (WordSize), mem_op (4), rdn (5), link (WordSize, captured pc_in+4), all registered.
REQ-015 SHALL have outputs store_data (WordSize) and byte_en (4), registered, lane-aligned store data and strobes.
REQ-016 SHALL have outputs redirect (1) and redirect_addr (WordSize), registered fetch redirect.
REQ-017 SHALL have output misaligned (1), registered address-misalignment flag.

Function
REQ-018 SHALL, when stall=0 and flush=0, capture all inputs on the rising edge; latency one cycle.
REQ-019 SHALL, when stall=1 and flush=0, hold every output except redirect.
REQ-020 SHALL, when flush=1, load valid=0, mem_op=0, byte_en=0, rdn=0, redirect=0, misaligned=0 regardless of stall; flush wins over stall.
REQ-021 SHALL set redirect=1 for exactly one cycle after a capture with valid_in=1 and branch_taken_in=1, with redirect_addr=branch_addr_in.
REQ-022 SHALL clear redirect on the next edge even if stall holds the rest of the stage; a held instruction never re-asserts redirect.
REQ-023 SHALL compute byte_en from mem_op_in and alu_out_in[1:0]: store byte -> 4'b0001<<addr[1:0]; store half -> 4'b0011<<addr[1:0]; store word -> 4'b1111; load or none -> 4'b0000.
REQ-024 SHALL replicate store data into lanes: byte -> rs2d_in[7:0] in all four lanes; half -> rs2d_in[15:0] in both halves; word -> rs2d_in unchanged.
REQ-025 SHALL flag misaligned=1 when size=half and addr[0]=1, or size=word and addr[1:0]!=0, gated by valid_in.
REQ-026 SHALL, when misaligned, force byte_en=0 and mem_op=0 while keeping valid, rdn and alu_out as captured.
REQ-027 SHALL compute link = pc_in + 4 modulo 2^WordSize, wrapping silently.
REQ-028 SHALL zero rdn, byte_en and mem_op when valid_in=0 at capture.

Reset
REQ-029 SHALL, on rstn low, asynchronously clear every output to 0 and hold them there until the first rising edge after rstn returns high.
REQ-030 SHALL abort a pending redirect on reset mid-operation; no redirect pulse is emitted after reset.

Structure
REQ-031 SHALL take the mem_op field positions, size encodings and the NOP constant from the shared core package, which IDEX decode also uses.
REQ-032 SHALL place byte_en, store_data and misaligned generation in one combinational sub-module, store_align.

Verification
REQ-033 SHALL verify: SW, alu_out_in=0x1000, rs2d_in=0xDEADBEEF -> next cycle byte_en=4'b1111, store_data=0xDEADBEEF, misaligned=0.
REQ-034 SHALL verify: SB, alu_out_in=0x1003, rs2d_in=0x000000A5 -> byte_en=4'b1000, store_data=0xA5A5A5A5.
REQ-035 SHALL verify: SH, alu_out_in=0x1001 -> misaligned=1, byte_en=0, mem_op=0, valid=1.
REQ-036 SHALL verify: taken branch, branch_addr_in=0x200, then stall held 3 cycles -> redirect high exactly one cycle, redirect_addr=0x200, other outputs held.
REQ-037 SHALL verify: stall=1 and flush=1 together -> bubble (valid=0, byte_en=0, rdn=0) on the next edge.
REQ-038 SHALL verify: rstn pulsed low mid-cycle after a taken-branch capture -> all outputs 0 immediately and no redirect afterward; pc_in=0xFFFFFFFC -> link=0x00000000.
